// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the decoder select-code scan sequencer.
package decoder_scan_pkg;

  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_FIRST_UP = 3'd0;
  localparam logic [SEL_W-1:0] SEL_LAST_UP  = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Scan configuration captured at start and held for the whole scan
  typedef struct packed {
    logic dir;
    logic once;
  } scan_cfg_t;

  function automatic logic [SEL_W-1:0] first_code(input logic dir);
    return dir ? SEL_LAST_UP : SEL_FIRST_UP;
  endfunction

  function automatic logic [SEL_W-1:0] last_code(input logic dir);
    return dir ? SEL_FIRST_UP : SEL_LAST_UP;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: latches the hold time on load and flags the last cycle of each dwell.
module dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick_c
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;

  // A dwell of zero is held as one so every code is visible for at least a cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      dwell_q <= '0;
    end else if (load) begin
      cnt_q   <= '0;
      dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick_c ? '0 : cnt_q + DWELL_W'(1);
    end
  end

  assign tick_c = (cnt_q == dwell_q - DWELL_W'(1));

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Programmable up/down select-code scanner feeding the z/a/b inputs of a 3-to-8 decoder.
module decoder_scan_sequencer
  import decoder_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               once,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_z,
  output logic               sel_a,
  output logic               sel_b,
  output logic               sel_valid,
  output logic               busy,
  output logic               pass_done,
  output logic [CNT_W-1:0]   pass_count
);

  scan_state_e      state_q, state_d;
  scan_cfg_t        cfg_q, cfg_d;
  logic [SEL_W-1:0] sel_d;
  logic             sel_valid_d;
  logic             busy_d;
  logic             pass_done_d;
  logic [CNT_W-1:0] pass_count_d;
  logic             load_c;
  logic             clear_c;
  logic             run_c;
  logic             tick_c;

  assign load_c  = (state_q == ST_IDLE) && start && !stop;
  assign clear_c = (state_q == ST_SCAN) && stop;
  assign run_c   = (state_q == ST_SCAN) && !stop;

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load_c),
    .clear  (clear_c),
    .run    (run_c),
    .dwell  (dwell),
    .tick_c (tick_c)
  );

  // Next-state and next-output logic; stop outranks both step and wrap
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    sel_d        = sel;
    sel_valid_d  = sel_valid;
    busy_d       = busy;
    pass_done_d  = 1'b0;
    pass_count_d = pass_count;

    case (state_q)
      ST_IDLE: begin
        if (load_c) begin
          state_d      = ST_SCAN;
          cfg_d.dir    = dir;
          cfg_d.once   = once;
          sel_d        = first_code(dir);
          pass_count_d = '0;
          sel_valid_d  = 1'b1;
          busy_d       = 1'b1;
        end
      end
      ST_SCAN: begin
        if (stop) begin
          state_d     = ST_IDLE;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (tick_c) begin
          if (sel == last_code(cfg_q.dir)) begin
            pass_done_d = 1'b1;
            if (pass_count != '1) begin
              pass_count_d = pass_count + CNT_W'(1);
            end
            if (cfg_q.once) begin
              state_d     = ST_IDLE;
              sel_valid_d = 1'b0;
              busy_d      = 1'b0;
            end else begin
              sel_d = first_code(cfg_q.dir);
            end
          end else begin
            sel_d = cfg_q.dir ? sel - SEL_W'(1) : sel + SEL_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      sel        <= '0;
      sel_valid  <= 1'b0;
      busy       <= 1'b0;
      pass_done  <= 1'b0;
      pass_count <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      sel        <= sel_d;
      sel_valid  <= sel_valid_d;
      busy       <= busy_d;
      pass_done  <= pass_done_d;
      pass_count <= pass_count_d;
    end
  end

  assign sel_z = sel[2];
  assign sel_a = sel[1];
  assign sel_b = sel[0];

endmodule
